// File: rtl/aq_dcache_tag_ctrl.sv
// Dcache tag-array access controller: arbitrates sweep > write > read onto one array port.
// Define AQ_LSU_DCACHE_INV_ALL_EN to build the whole-cache invalidate sweep FSM.
module aq_dcache_tag_ctrl #(
    parameter int SET_NUM = 64,
    parameter int SET_W   = 6
) (
    input  logic         forever_cpuclk,
    input  logic         cpurst_b,
    input  logic         cp0_lsu_icg_en,
    input  logic         rd_req,
    input  logic [11:0]  rd_idx,
    input  logic [3:0]   rd_way,
    output logic         rd_gnt,
    output logic         rd_vld,
    output logic [119:0] rd_dout,
    input  logic         wr_req,
    input  logic [11:0]  wr_idx,
    input  logic [3:0]   wr_way,
    input  logic [119:0] wr_din,
    input  logic [119:0] wr_wen,
    output logic         wr_gnt,
    input  logic         inv_all_req,
    output logic         inv_all_busy,
    output logic         inv_all_done,
    output logic         tag_cen,
    output logic         tag_gwen,
    output logic         tag_clk_en,
    output logic [11:0]  tag_idx,
    output logic [3:0]   tag_way,
    output logic [119:0] tag_din,
    output logic [119:0] tag_wen,
    input  logic [119:0] tag_dout
);

    logic        sweep_on;
    logic        arb_block;
    logic [11:0] sweep_idx;
    logic        rd_vld_q;
    logic        unused_icg;

    assign unused_icg = cp0_lsu_icg_en;

`ifdef AQ_LSU_DCACHE_INV_ALL_EN
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam logic [SET_W-1:0] CNT_LAST = SET_W'(SET_NUM - 1);

    state_t           state_q;
    state_t           state_d;
    logic [SET_W-1:0] cnt_q;
    logic [SET_W-1:0] cnt_d;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Requests seen while busy are dropped; only IDLE looks at inv_all_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (inv_all_req) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sweep_idx              = '0;
        sweep_idx[6 +: SET_W]  = cnt_q;
    end

    assign sweep_on     = cpurst_b && (state_q == SWEEP);
    assign arb_block    = (state_q != IDLE);
    assign inv_all_busy = cpurst_b && arb_block;
    assign inv_all_done = cpurst_b && (state_q == DONE);
`else
    logic             inv_req_q;
    logic             done_q;
    logic [SET_W-1:0] unused_set;

    assign unused_set = SET_W'(SET_NUM);

    // No sweep: acknowledge each new invalidate request one cycle later.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            inv_req_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            inv_req_q <= inv_all_req;
            done_q    <= inv_all_req && !inv_req_q;
        end
    end

    assign sweep_on     = 1'b0;
    assign arb_block    = 1'b0;
    assign sweep_idx    = '0;
    assign inv_all_busy = 1'b0;
    assign inv_all_done = cpurst_b && done_q;
`endif

    always_comb begin
        rd_gnt     = 1'b0;
        wr_gnt     = 1'b0;
        tag_cen    = 1'b1;
        tag_gwen   = 1'b1;
        tag_clk_en = 1'b0;
        tag_idx    = '0;
        tag_way    = '0;
        tag_din    = '0;
        tag_wen    = '1;
        if (sweep_on) begin
            tag_cen    = 1'b0;
            tag_gwen   = 1'b0;
            tag_clk_en = 1'b1;
            tag_idx    = sweep_idx;
            tag_way    = 4'b1111;
            tag_wen    = '0;
        end else if (cpurst_b && !arb_block && wr_req) begin
            wr_gnt     = 1'b1;
            tag_cen    = 1'b0;
            tag_gwen   = 1'b0;
            tag_clk_en = 1'b1;
            tag_idx    = wr_idx;
            tag_way    = wr_way;
            tag_din    = wr_din;
            tag_wen    = wr_wen;
        end else if (cpurst_b && !arb_block && rd_req) begin
            rd_gnt     = 1'b1;
            tag_cen    = 1'b0;
            tag_clk_en = 1'b1;
            tag_idx    = rd_idx;
            tag_way    = rd_way;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_gnt;
        end
    end

    assign rd_vld  = cpurst_b && rd_vld_q;
    assign rd_dout = rd_vld ? tag_dout : '0;

endmodule

// File: tb/tb_aq_dcache_tag_ctrl.sv
// Directed bench for aq_dcache_tag_ctrl; sweep scenarios build only with
// AQ_LSU_DCACHE_INV_ALL_EN, the acknowledge-only path otherwise.
module tb_aq_dcache_tag_ctrl;

    localparam logic [119:0] ONES = {120{1'b1}};
    localparam logic [119:0] PAT  = 120'h23_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [119:0] MASK = {{60{1'b1}}, {60{1'b0}}};

    logic         clk = 1'b0;
    logic         cpurst_b;
    logic         cp0_lsu_icg_en;
    logic         rd_req;
    logic [11:0]  rd_idx;
    logic [3:0]   rd_way;
    logic         rd_gnt;
    logic         rd_vld;
    logic [119:0] rd_dout;
    logic         wr_req;
    logic [11:0]  wr_idx;
    logic [3:0]   wr_way;
    logic [119:0] wr_din;
    logic [119:0] wr_wen;
    logic         wr_gnt;
    logic         inv_all_req;
    logic         inv_all_busy;
    logic         inv_all_done;
    logic         tag_cen;
    logic         tag_gwen;
    logic         tag_clk_en;
    logic [11:0]  tag_idx;
    logic [3:0]   tag_way;
    logic [119:0] tag_din;
    logic [119:0] tag_wen;
    logic [119:0] tag_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aq_dcache_tag_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .cp0_lsu_icg_en (cp0_lsu_icg_en),
        .rd_req         (rd_req),
        .rd_idx         (rd_idx),
        .rd_way         (rd_way),
        .rd_gnt         (rd_gnt),
        .rd_vld         (rd_vld),
        .rd_dout        (rd_dout),
        .wr_req         (wr_req),
        .wr_idx         (wr_idx),
        .wr_way         (wr_way),
        .wr_din         (wr_din),
        .wr_wen         (wr_wen),
        .wr_gnt         (wr_gnt),
        .inv_all_req    (inv_all_req),
        .inv_all_busy   (inv_all_busy),
        .inv_all_done   (inv_all_done),
        .tag_cen        (tag_cen),
        .tag_gwen       (tag_gwen),
        .tag_clk_en     (tag_clk_en),
        .tag_idx        (tag_idx),
        .tag_way        (tag_way),
        .tag_din        (tag_din),
        .tag_wen        (tag_wen),
        .tag_dout       (tag_dout)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic drive_idle;
        rd_req      = 1'b0;
        rd_idx      = '0;
        rd_way      = '0;
        wr_req      = 1'b0;
        wr_idx      = '0;
        wr_way      = '0;
        wr_din      = '0;
        wr_wen      = ONES;
        inv_all_req = 1'b0;
    endtask

    task automatic test_reset;
        rd_req = 1'b1;
        rd_idx = 12'h155;
        rd_way = 4'b0001;
        wr_req = 1'b1;
        wr_idx = 12'h2AA;
        wr_din = PAT;
        wr_wen = '0;
        sample;
        checks++;
        if ({rd_gnt, wr_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 00", {rd_gnt, wr_gnt});
        end
        checks++;
        if ({tag_cen, tag_gwen, tag_clk_en} !== 3'b110) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 110", {tag_cen, tag_gwen, tag_clk_en});
        end
        checks++;
        if (tag_wen !== ONES || {tag_idx, tag_way, tag_din} !== 136'd0) begin
            errors++;
            $display("FAIL reset_data: idx=%h way=%h din=%h wen=%h", tag_idx, tag_way, tag_din, tag_wen);
        end
        checks++;
        if ({rd_vld, inv_all_busy, inv_all_done} !== 3'b000 || rd_dout !== 120'd0) begin
            errors++;
            $display("FAIL reset_status: vld/busy/done=%b dout=%h want 000/0",
                     {rd_vld, inv_all_busy, inv_all_done}, rd_dout);
        end
        next_cycle;
        cpurst_b = 1'b1;
        drive_idle;
        sample;
        checks++;
        if ({tag_cen, tag_gwen, tag_clk_en, rd_gnt, wr_gnt, inv_all_busy} !== 6'b110000) begin
            errors++;
            $display("FAIL idle_ctl: got %b want 110000",
                     {tag_cen, tag_gwen, tag_clk_en, rd_gnt, wr_gnt, inv_all_busy});
        end
        next_cycle;
    endtask

    task automatic test_read;
        rd_req   = 1'b1;
        rd_idx   = 12'h3C0;
        rd_way   = 4'b0100;
        tag_dout = PAT;
        sample;
        checks++;
        if ({rd_gnt, wr_gnt, tag_cen, tag_gwen, tag_clk_en} !== 5'b10011) begin
            errors++;
            $display("FAIL read_grant: gnt/ctl=%b want 10011",
                     {rd_gnt, wr_gnt, tag_cen, tag_gwen, tag_clk_en});
        end
        checks++;
        if ({tag_idx, tag_way} !== {12'h3C0, 4'b0100}) begin
            errors++;
            $display("FAIL read_addr: idx=%h way=%b want 3c0/0100", tag_idx, tag_way);
        end
        checks++;
        if (rd_vld !== 1'b0 || rd_dout !== 120'd0) begin
            errors++;
            $display("FAIL read_early_vld: vld=%b dout=%h want 0/0", rd_vld, rd_dout);
        end
        next_cycle;
        rd_req = 1'b0;
        sample;
        checks++;
        if (rd_vld !== 1'b1 || rd_dout !== PAT) begin
            errors++;
            $display("FAIL read_data: vld=%b dout=%h want 1/%h", rd_vld, rd_dout, PAT);
        end
        checks++;
        if ({tag_cen, rd_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL read_release: cen/gnt=%b want 10", {tag_cen, rd_gnt});
        end
        next_cycle;
        tag_dout = ~PAT;
        sample;
        checks++;
        if (rd_vld !== 1'b0 || rd_dout !== 120'd0) begin
            errors++;
            $display("FAIL read_vld_drop: vld=%b dout=%h want 0/0", rd_vld, rd_dout);
        end
        next_cycle;
    endtask

    task automatic test_write;
        wr_req = 1'b1;
        wr_idx = 12'hA85;
        wr_way = 4'b0010;
        wr_din = PAT;
        wr_wen = MASK;
        sample;
        checks++;
        if ({wr_gnt, rd_gnt, tag_cen, tag_gwen, tag_clk_en} !== 5'b10001) begin
            errors++;
            $display("FAIL write_grant: gnt/ctl=%b want 10001",
                     {wr_gnt, rd_gnt, tag_cen, tag_gwen, tag_clk_en});
        end
        checks++;
        if ({tag_idx, tag_way} !== {12'hA85, 4'b0010}) begin
            errors++;
            $display("FAIL write_addr: idx=%h way=%b want a85/0010", tag_idx, tag_way);
        end
        checks++;
        if (tag_din !== PAT || tag_wen !== MASK) begin
            errors++;
            $display("FAIL write_data: din=%h wen=%h want %h/%h", tag_din, tag_wen, PAT, MASK);
        end
        next_cycle;
        drive_idle;
        sample;
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL write_no_vld: vld=%b want 0", rd_vld);
        end
        next_cycle;
    endtask

    task automatic test_collision;
        rd_req   = 1'b1;
        rd_idx   = 12'h0C0;
        rd_way   = 4'b1000;
        wr_req   = 1'b1;
        wr_idx   = 12'hFC0;
        wr_way   = 4'b0001;
        wr_din   = ~PAT;
        wr_wen   = '0;
        tag_dout = MASK;
        sample;
        checks++;
        if ({wr_gnt, rd_gnt, tag_gwen} !== 3'b100 || tag_idx !== 12'hFC0) begin
            errors++;
            $display("FAIL collide_wr: wr/rd/gwen=%b idx=%h want 100/fc0",
                     {wr_gnt, rd_gnt, tag_gwen}, tag_idx);
        end
        next_cycle;
        wr_req = 1'b0;
        sample;
        checks++;
        if ({wr_gnt, rd_gnt, tag_gwen} !== 3'b011 || tag_idx !== 12'h0C0) begin
            errors++;
            $display("FAIL collide_rd: wr/rd/gwen=%b idx=%h want 011/0c0",
                     {wr_gnt, rd_gnt, tag_gwen}, tag_idx);
        end
        next_cycle;
        rd_req = 1'b0;
        sample;
        checks++;
        if (rd_vld !== 1'b1 || rd_dout !== MASK) begin
            errors++;
            $display("FAIL collide_vld: vld=%b dout=%h want 1/%h", rd_vld, rd_dout, MASK);
        end
        next_cycle;
    endtask

    task automatic test_rd_vld_reset;
        rd_req   = 1'b1;
        rd_idx   = 12'h240;
        rd_way   = 4'b0010;
        tag_dout = PAT;
        sample;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstvld_gnt: got %b want 1", rd_gnt);
        end
        next_cycle;
        rd_req   = 1'b0;
        cpurst_b = 1'b0;
        sample;
        checks++;
        if (rd_vld !== 1'b0 || rd_dout !== 120'd0) begin
            errors++;
            $display("FAIL rstvld_in_reset: vld=%b dout=%h want 0/0", rd_vld, rd_dout);
        end
        next_cycle;
        cpurst_b = 1'b1;
        sample;
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL rstvld_after: vld=%b want 0", rd_vld);
        end
        next_cycle;
    endtask

`ifdef AQ_LSU_DCACHE_INV_ALL_EN
    task automatic test_sweep;
        logic [22:0] got;
        logic [22:0] exp;
        inv_all_req = 1'b1;
        rd_req      = 1'b1;
        rd_idx      = 12'h040;
        rd_way      = 4'b0001;
        sample;
        checks++;
        if ({rd_gnt, inv_all_busy, tag_gwen} !== 3'b101) begin
            errors++;
            $display("FAIL sweep_same_cycle: gnt/busy/gwen=%b want 101",
                     {rd_gnt, inv_all_busy, tag_gwen});
        end
        next_cycle;
        inv_all_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sample;
            got = {tag_cen, tag_gwen, tag_clk_en, tag_way, tag_idx,
                   rd_gnt, wr_gnt, inv_all_busy, inv_all_done};
            exp = {3'b001, 4'b1111, i[5:0], 6'b0, 4'b0010};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sweep_step%0d: got %h want %h", i, got, exp);
            end
            checks++;
            if ({tag_din, tag_wen} !== 240'd0) begin
                errors++;
                $display("FAIL sweep_data%0d: din=%h wen=%h want 0/0", i, tag_din, tag_wen);
            end
            next_cycle;
        end
        sample;
        checks++;
        if ({tag_cen, tag_gwen, tag_clk_en, rd_gnt, inv_all_busy, inv_all_done} !== 6'b110011) begin
            errors++;
            $display("FAIL sweep_done: got %b want 110011",
                     {tag_cen, tag_gwen, tag_clk_en, rd_gnt, inv_all_busy, inv_all_done});
        end
        next_cycle;
        sample;
        checks++;
        if ({rd_gnt, inv_all_busy, inv_all_done} !== 3'b100 || tag_idx !== 12'h040) begin
            errors++;
            $display("FAIL sweep_exit: gnt/busy/done=%b idx=%h want 100/040",
                     {rd_gnt, inv_all_busy, inv_all_done}, tag_idx);
        end
        next_cycle;
        rd_req = 1'b0;
        sample;
        checks++;
        if (rd_vld !== 1'b1) begin
            errors++;
            $display("FAIL sweep_exit_vld: vld=%b want 1", rd_vld);
        end
        next_cycle;
    endtask

    task automatic test_retrigger;
        inv_all_req = 1'b1;
        next_cycle;
        inv_all_req = 1'b0;
        wr_req      = 1'b1;
        wr_idx      = 12'h7C0;
        wr_way      = 4'b1000;
        wr_din      = PAT;
        wr_wen      = '0;
        for (int i = 0; i < 64; i++) begin
            inv_all_req = (i >= 10 && i <= 12);
            sample;
            checks++;
            if ({wr_gnt, rd_gnt, inv_all_busy, inv_all_done} !== 4'b0010 ||
                tag_idx !== {i[5:0], 6'b0}) begin
                errors++;
                $display("FAIL retrig_step%0d: wr/rd/busy/done=%b idx=%h",
                         i, {wr_gnt, rd_gnt, inv_all_busy, inv_all_done}, tag_idx);
            end
            next_cycle;
        end
        inv_all_req = 1'b0;
        sample;
        checks++;
        if ({wr_gnt, inv_all_busy, inv_all_done} !== 3'b011) begin
            errors++;
            $display("FAIL retrig_done: wr/busy/done=%b want 011",
                     {wr_gnt, inv_all_busy, inv_all_done});
        end
        next_cycle;
        sample;
        checks++;
        if ({wr_gnt, tag_gwen, inv_all_busy, inv_all_done} !== 4'b1000 || tag_idx !== 12'h7C0) begin
            errors++;
            $display("FAIL retrig_wr: wr/gwen/busy/done=%b idx=%h want 1000/7c0",
                     {wr_gnt, tag_gwen, inv_all_busy, inv_all_done}, tag_idx);
        end
        next_cycle;
        wr_req = 1'b0;
        sample;
        checks++;
        if ({inv_all_busy, tag_cen} !== 2'b01) begin
            errors++;
            $display("FAIL retrig_idle: busy/cen=%b want 01", {inv_all_busy, tag_cen});
        end
        next_cycle;
    endtask

    task automatic test_mid_reset;
        logic seen;
        inv_all_req = 1'b1;
        next_cycle;
        inv_all_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample;
            checks++;
            if (tag_idx !== {i[5:0], 6'b0}) begin
                errors++;
                $display("FAIL midrst_step%0d: idx=%h want %h", i, tag_idx, {i[5:0], 6'b0});
            end
            next_cycle;
        end
        cpurst_b = 1'b0;
        sample;
        checks++;
        if ({inv_all_busy, inv_all_done, tag_cen, tag_clk_en} !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_hold: busy/done/cen/clken=%b want 0010",
                     {inv_all_busy, inv_all_done, tag_cen, tag_clk_en});
        end
        next_cycle;
        cpurst_b = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 70; i++) begin
            sample;
            seen = seen | inv_all_busy | inv_all_done | ~tag_cen;
            next_cycle;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_aborted: busy/done/access seen=%b want 0", seen);
        end
        inv_all_req = 1'b1;
        next_cycle;
        inv_all_req = 1'b0;
        sample;
        checks++;
        if ({inv_all_busy, tag_gwen} !== 2'b10 || tag_idx !== 12'h000) begin
            errors++;
            $display("FAIL midrst_restart: busy/gwen=%b idx=%h want 10/000",
                     {inv_all_busy, tag_gwen}, tag_idx);
        end
        repeat (64) next_cycle;
        sample;
        checks++;
        if ({inv_all_busy, inv_all_done} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_done: busy/done=%b want 11", {inv_all_busy, inv_all_done});
        end
        next_cycle;
        sample;
        checks++;
        if ({inv_all_busy, inv_all_done} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_end: busy/done=%b want 00", {inv_all_busy, inv_all_done});
        end
        next_cycle;
    endtask
`else
    task automatic test_no_sweep;
        inv_all_req = 1'b1;
        rd_req      = 1'b1;
        rd_idx      = 12'h100;
        rd_way      = 4'b0010;
        tag_dout    = PAT;
        sample;
        checks++;
        if ({rd_gnt, inv_all_busy, inv_all_done, tag_gwen} !== 4'b1001) begin
            errors++;
            $display("FAIL nosweep_req: gnt/busy/done/gwen=%b want 1001",
                     {rd_gnt, inv_all_busy, inv_all_done, tag_gwen});
        end
        next_cycle;
        rd_req = 1'b0;
        sample;
        checks++;
        if ({inv_all_done, inv_all_busy, rd_vld} !== 3'b101) begin
            errors++;
            $display("FAIL nosweep_done: done/busy/vld=%b want 101",
                     {inv_all_done, inv_all_busy, rd_vld});
        end
        next_cycle;
        sample;
        checks++;
        if ({inv_all_done, inv_all_busy} !== 2'b00) begin
            errors++;
            $display("FAIL nosweep_held: done/busy=%b want 00", {inv_all_done, inv_all_busy});
        end
        next_cycle;
        inv_all_req = 1'b0;
        sample;
        checks++;
        if (inv_all_done !== 1'b0) begin
            errors++;
            $display("FAIL nosweep_low: done=%b want 0", inv_all_done);
        end
        next_cycle;
        inv_all_req = 1'b1;
        wr_req      = 1'b1;
        wr_idx      = 12'h5C0;
        wr_wen      = '0;
        sample;
        checks++;
        if ({wr_gnt, inv_all_busy, inv_all_done, tag_gwen} !== 4'b1000 || tag_idx !== 12'h5C0) begin
            errors++;
            $display("FAIL nosweep_wr: wr/busy/done/gwen=%b idx=%h want 1000/5c0",
                     {wr_gnt, inv_all_busy, inv_all_done, tag_gwen}, tag_idx);
        end
        next_cycle;
        inv_all_req = 1'b0;
        wr_req      = 1'b0;
        sample;
        checks++;
        if ({inv_all_done, inv_all_busy} !== 2'b10) begin
            errors++;
            $display("FAIL nosweep_done2: done/busy=%b want 10", {inv_all_done, inv_all_busy});
        end
        next_cycle;
        sample;
        checks++;
        if (inv_all_done !== 1'b0) begin
            errors++;
            $display("FAIL nosweep_pulse: done=%b want 0", inv_all_done);
        end
        next_cycle;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle;
        cpurst_b       = 1'b0;
        cp0_lsu_icg_en = 1'b1;
        tag_dout       = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_read;
        test_write;
        test_collision;
        test_rd_vld_reset;
`ifdef AQ_LSU_DCACHE_INV_ALL_EN
        test_sweep;
        test_retrigger;
        test_mid_reset;
`else
        test_no_sweep;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
